// File: rtl/seven_segment_capture.sv
// seven_segment_capture
// Recovers the two hex digits shown on a multiplexed dual-digit seven-segment
// display by watching its segment bus and anode enables. Each anode/segment
// combination must hold still for SETTLE_CYCLES synchronized cycles before it
// is decoded. The right and left captures are then reassembled into one frame.

module seven_segment_capture #(
    parameter int SETTLE_CYCLES = 8,   // legal range 2..255
    parameter int SYNC_STAGES   = 2    // legal range 2..3
) (
    input  logic       clk,
    input  logic       reset,          // asynchronous, active-low
    input  logic [6:0] seg,            // active-low segments, seg[0]=a .. seg[6]=g
    input  logic [1:0] an,             // active-low anodes, an[0]=right, an[1]=left
    output logic [3:0] digit_r,
    output logic [3:0] digit_l,
    output logic       frame_valid,
    output logic       pattern_err,
    output logic       overlap_err
);

    typedef enum logic [1:0] {
        IDLE,    // display blanked (both anodes off)
        SETTLE,  // waiting for the current combination to hold long enough
        DONE     // this window has already been acted on
    } state_t;

    localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_TRIG = 8'(SETTLE_CYCLES - 2);

    // Maps an active-low segment pattern to {legal, value}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pattern);
        logic [4:0] result;
        case (pattern)
            7'h40:   result = {1'b1, 4'h0};
            7'h79:   result = {1'b1, 4'h1};
            7'h24:   result = {1'b1, 4'h2};
            7'h30:   result = {1'b1, 4'h3};
            7'h19:   result = {1'b1, 4'h4};
            7'h12:   result = {1'b1, 4'h5};
            7'h02:   result = {1'b1, 4'h6};
            7'h78:   result = {1'b1, 4'h7};
            7'h00:   result = {1'b1, 4'h8};
            7'h10:   result = {1'b1, 4'h9};
            7'h08:   result = {1'b1, 4'hA};
            7'h03:   result = {1'b1, 4'hB};
            7'h46:   result = {1'b1, 4'hC};
            7'h21:   result = {1'b1, 4'hD};
            7'h06:   result = {1'b1, 4'hE};
            7'h0E:   result = {1'b1, 4'hF};
            default: result = 5'b0_0000;
        endcase
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [6:0] seg_sync_q [SYNC_STAGES];
    logic [1:0] an_sync_q  [SYNC_STAGES];
    logic [6:0] s_seg;
    logic [1:0] s_an;

    // Shift seg and an through SYNC_STAGES flops; reset to the all-off pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                seg_sync_q[i] <= '1;
                an_sync_q[i]  <= '1;
            end
        end else begin
            seg_sync_q[0] <= seg;
            an_sync_q[0]  <= an;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                seg_sync_q[i] <= seg_sync_q[i-1];
                an_sync_q[i]  <= an_sync_q[i-1];
            end
        end
    end

    assign s_seg = seg_sync_q[SYNC_STAGES-1];
    assign s_an  = an_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Stability tracking, capture FSM and frame assembly
    // ------------------------------------------------------------------
    state_t     state_q,       state_d;
    logic [8:0] win_q,         win_d;         // {s_an, s_seg} seen last cycle
    logic [7:0] cnt_q,         cnt_d;
    logic [3:0] slot_r_q,      slot_r_d;
    logic [3:0] slot_l_q,      slot_l_d;
    logic       got_r_q,       got_r_d;
    logic       got_l_q,       got_l_d;
    logic [3:0] digit_r_q,     digit_r_d;
    logic [3:0] digit_l_q,     digit_l_d;
    logic       frame_valid_q, frame_valid_d;
    logic       pattern_err_q, pattern_err_d;
    logic       overlap_err_q, overlap_err_d;

    logic [8:0] cur_win;
    logic       changed;
    logic [4:0] glyph;
    logic       act;

    assign cur_win = {s_an, s_seg};
    assign changed = (cur_win != win_q);
    assign glyph   = decode_glyph(s_seg);

    // Next-state logic: restart on any change, act once per settled window.
    always_comb begin
        // NOTE: every signal gets a default here so no latch is inferred.
        state_d       = state_q;
        win_d         = cur_win;
        cnt_d         = cnt_q;
        slot_r_d      = slot_r_q;
        slot_l_d      = slot_l_q;
        got_r_d       = got_r_q;
        got_l_d       = got_l_q;
        digit_r_d     = digit_r_q;
        digit_l_d     = digit_l_q;
        frame_valid_d = 1'b0;
        pattern_err_d = 1'b0;
        overlap_err_d = 1'b0;
        act           = 1'b0;

        if (changed) begin
            cnt_d   = '0;
            state_d = (s_an == 2'b11) ? IDLE : SETTLE;
        end else begin
            if (cnt_q < SETTLE_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
            // The counter reaches SETTLE_CYCLES-1 on this edge.
            if (state_q == SETTLE && cnt_q == SETTLE_TRIG) begin
                state_d = DONE;
                act     = 1'b1;
            end
        end

        // Both slots filled last cycle: publish the frame. A capture on this
        // same cycle is applied afterwards so it is never lost.
        if (got_r_q && got_l_q) begin
            digit_r_d     = slot_r_q;
            digit_l_d     = slot_l_q;
            frame_valid_d = 1'b1;
            got_r_d       = 1'b0;
            got_l_d       = 1'b0;
        end

        if (act) begin
            unique case (s_an)
                2'b10: begin
                    if (glyph[4]) begin
                        slot_r_d = glyph[3:0];
                        got_r_d  = 1'b1;
                    end else begin
                        pattern_err_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (glyph[4]) begin
                        slot_l_d = glyph[3:0];
                        got_l_d  = 1'b1;
                    end else begin
                        pattern_err_d = 1'b1;
                    end
                end
                2'b00:   overlap_err_d = 1'b1;
                default: ;  // blanked windows never reach SETTLE
            endcase
        end
    end

    // State and output registers; reset discards partial windows and slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            win_q         <= '1;
            cnt_q         <= '0;
            slot_r_q      <= '0;
            slot_l_q      <= '0;
            got_r_q       <= 1'b0;
            got_l_q       <= 1'b0;
            digit_r_q     <= '0;
            digit_l_q     <= '0;
            frame_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            overlap_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q       <= state_d;
            win_q         <= win_d;
            cnt_q         <= cnt_d;
            slot_r_q      <= slot_r_d;
            slot_l_q      <= slot_l_d;
            got_r_q       <= got_r_d;
            got_l_q       <= got_l_d;
            digit_r_q     <= digit_r_d;
            digit_l_q     <= digit_l_d;
            frame_valid_q <= frame_valid_d;
            pattern_err_q <= pattern_err_d;
            overlap_err_q <= overlap_err_d;
        end
    end

    assign digit_r     = digit_r_q;
    assign digit_l     = digit_l_q;
    assign frame_valid = frame_valid_q;
    assign pattern_err = pattern_err_q;
    assign overlap_err = overlap_err_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: a table of held display states
// with hand-computed pulse counts and digits, plus sequences for fast
// toggling, the exact settle boundary and reset in the middle of a frame.

module tb_seven_segment_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit_r;
    logic [3:0] digit_l;
    logic       frame_valid;
    logic       pattern_err;
    logic       overlap_err;

    int total = 0;
    int bad   = 0;

    seven_segment_capture #(
        .SETTLE_CYCLES(8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg        (seg),
        .an         (an),
        .digit_r    (digit_r),
        .digit_l    (digit_l),
        .frame_valid(frame_valid),
        .pattern_err(pattern_err),
        .overlap_err(overlap_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        int         cycles;
        int         exp_frame;
        int         exp_pat;
        int         exp_ovl;
        logic [3:0] exp_r;
        logic [3:0] exp_l;
        int         exp_first;   // cycle of first pulse in the row, 0 = none expected
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one held combination and count pulses; cycle 1 is the first edge
    // after the pins change.
    task automatic hold(input logic [1:0] a, input logic [6:0] s, input int cycles,
                        inout int n_frame, inout int n_pat, inout int n_ovl,
                        output int first);
        an    = a;
        seg   = s;
        first = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid) n_frame++;
            if (pattern_err) n_pat++;
            if (overlap_err) n_ovl++;
            if ((frame_valid || pattern_err || overlap_err) && first == 0) first = i;
        end
    endtask

    vec_t vecs [14];
    logic [6:0] glyphs [16];

    initial begin
        int nf, np, no, first;

        glyphs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        //         an     seg    cyc frm pat ovl  r     l     first
        vecs[0]  = '{2'b11, 7'h7F, 50, 0, 0, 0, 4'h0, 4'h0, 0};
        vecs[1]  = '{2'b10, 7'h30, 20, 0, 0, 0, 4'h0, 4'h0, 0};
        vecs[2]  = '{2'b01, 7'h24, 20, 1, 0, 0, 4'h3, 4'h2, 11};
        vecs[3]  = '{2'b10, 7'h30, 20, 0, 0, 0, 4'h3, 4'h2, 0};
        vecs[4]  = '{2'b01, 7'h24, 20, 1, 0, 0, 4'h3, 4'h2, 11};
        vecs[5]  = '{2'b11, 7'h7F, 20, 0, 0, 0, 4'h3, 4'h2, 0};
        vecs[6]  = '{2'b01, 7'h7F, 20, 0, 1, 0, 4'h3, 4'h2, 10};
        vecs[7]  = '{2'b00, 7'h00, 20, 0, 0, 1, 4'h3, 4'h2, 10};
        vecs[8]  = '{2'b10, 7'h79, 20, 0, 0, 0, 4'h3, 4'h2, 0};
        vecs[9]  = '{2'b01, 7'h12, 20, 1, 0, 0, 4'h1, 4'h5, 11};
        vecs[10] = '{2'b01, 7'h0E, 20, 0, 0, 0, 4'h1, 4'h5, 0};
        vecs[11] = '{2'b01, 7'h06, 20, 0, 0, 0, 4'h1, 4'h5, 0};
        vecs[12] = '{2'b10, 7'h40, 20, 1, 0, 0, 4'h0, 4'hE, 11};
        vecs[13] = '{2'b10, 7'h7F, 20, 0, 1, 0, 4'h0, 4'hE, 10};

        // Reset with the display blanked.
        reset = 1'b0;
        an    = 2'b11;
        seg   = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digit_r", int'(digit_r), 0);
        check("reset_digit_l", int'(digit_l), 0);
        check("reset_pulses", int'({frame_valid, pattern_err, overlap_err}), 0);
        reset = 1'b1;

        // Table of held windows.
        for (int v = 0; v < 14; v++) begin
            nf = 0; np = 0; no = 0;
            hold(vecs[v].an, vecs[v].seg, vecs[v].cycles, nf, np, no, first);
            check($sformatf("row%0d_frame", v), nf, vecs[v].exp_frame);
            check($sformatf("row%0d_pattern_err", v), np, vecs[v].exp_pat);
            check($sformatf("row%0d_overlap_err", v), no, vecs[v].exp_ovl);
            check($sformatf("row%0d_digit_r", v), int'(digit_r), int'(vecs[v].exp_r));
            check($sformatf("row%0d_digit_l", v), int'(digit_l), int'(vecs[v].exp_l));
            if (vecs[v].exp_first != 0)
                check($sformatf("row%0d_latency", v), first, vecs[v].exp_first);
        end

        // Segments changing every 4 cycles never settle, then blank.
        nf = 0; np = 0; no = 0;
        for (int k = 0; k < 25; k++)
            hold(2'b10, glyphs[k % 16], 4, nf, np, no, first);
        hold(2'b11, 7'h7F, 20, nf, np, no, first);
        check("fast_frame", nf, 0);
        check("fast_pattern_err", np, 0);
        check("fast_overlap_err", no, 0);
        check("fast_digit_r", int'(digit_r), 0);
        check("fast_digit_l", int'(digit_l), 14);

        // Settle boundary: 8 stable pin cycles capture, 7 do not.
        nf = 0; np = 0; no = 0;
        hold(2'b10, 7'h19, 8, nf, np, no, first);   // right = 4
        hold(2'b10, 7'h12, 7, nf, np, no, first);   // too short, must not replace 4
        hold(2'b01, 7'h40, 20, nf, np, no, first);  // left = 0 -> frame
        check("edge_frame", nf, 1);
        check("edge_errs", np + no, 0);
        check("edge_digit_r", int'(digit_r), 4);
        check("edge_digit_l", int'(digit_l), 0);

        // Reset between a right capture and a left capture.
        nf = 0; np = 0; no = 0;
        hold(2'b10, 7'h0E, 20, nf, np, no, first);  // right = F, waiting for left
        check("pre_reset_frame", nf, 0);
        reset = 1'b0;
        an    = 2'b01;
        seg   = 7'h08;
        @(posedge clk);
        #1;
        check("mid_reset_digit_r", int'(digit_r), 0);
        check("mid_reset_digit_l", int'(digit_l), 0);
        check("mid_reset_frame", int'(frame_valid), 0);
        reset = 1'b1;
        hold(2'b01, 7'h08, 20, nf, np, no, first);  // left = A, right slot was discarded
        check("post_reset_no_frame", nf, 0);
        hold(2'b10, 7'h79, 20, nf, np, no, first);  // right = 1 -> frame
        check("post_reset_frame", nf, 1);
        check("post_reset_latency", first, 11);
        check("post_reset_errs", np + no, 0);
        check("post_reset_digit_r", int'(digit_r), 1);
        check("post_reset_digit_l", int'(digit_l), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
